// File: rtl/single_cycle_cpu_if.sv
// Debug bus of the single-cycle CPU: current PC, instruction word
// and ALU result.
interface single_cycle_cpu_if;
   logic [31:0] PC;
   logic [31:0] INST;
   logic [31:0] R;

   modport master (output PC, INST, R);
   modport slave  (input  PC, INST, R);
endinterface

// File: rtl/single_cycle_cpu.sv
// Single-cycle MIPS-subset CPU: fetch, decode, execute and retire
// one instruction per clock. The ROM image is supplied as an array parameter.
module single_cycle_cpu #(
   parameter int          MEM_WORDS = 64,
   parameter logic [31:0] IMEM_INIT [MEM_WORDS] = '{default: 32'h0}
) (
   input  logic               CLK,
   input  logic               RST_N,
   single_cycle_cpu_if.master dbg
);
   localparam int AW = $clog2(MEM_WORDS);

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2B;
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_J    = 6'h02;

   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_SLT = 6'h2A;

   logic [31:0] pc;
   logic [31:0] inst;
   logic [31:0] regs [32];
   logic [31:0] ram  [MEM_WORDS];

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [31:0] simm;
   logic [31:0] rs_val;
   logic [31:0] rt_val;

   logic [31:0] pc_inc;
   logic [31:0] br_tgt;
   logic [31:0] j_tgt;
   logic [31:0] next_pc;
   logic [31:0] alu_r;
   logic [31:0] rd_mem;
   logic [31:0] wdata;
   logic [4:0]  wsel;
   logic        reg_we;
   logic        mem_we;
   logic [AW-1:0] maddr;

   logic is_r;
   logic is_add;
   logic is_sub;
   logic is_and;
   logic is_or;
   logic is_slt;
   logic is_addi;
   logic is_lw;
   logic is_sw;
   logic is_beq;
   logic is_j;

   assign inst  = IMEM_INIT[pc[AW+1:2]];
   assign op    = inst[31:26];
   assign rs    = inst[25:21];
   assign rt    = inst[20:16];
   assign rd    = inst[15:11];
   assign funct = inst[5:0];
   assign simm  = {{16{inst[15]}}, inst[15:0]};

   assign rs_val = regs[rs];
   assign rt_val = regs[rt];

   assign is_r    = (op == OP_R);
   assign is_add  = is_r && (funct == F_ADD);
   assign is_sub  = is_r && (funct == F_SUB);
   assign is_and  = is_r && (funct == F_AND);
   assign is_or   = is_r && (funct == F_OR);
   assign is_slt  = is_r && (funct == F_SLT);
   assign is_addi = (op == OP_ADDI);
   assign is_lw   = (op == OP_LW);
   assign is_sw   = (op == OP_SW);
   assign is_beq  = (op == OP_BEQ);
   assign is_j    = (op == OP_J);

   assign pc_inc = pc + 32'd4;
   assign br_tgt = pc_inc + {simm[29:0], 2'b00};
   assign j_tgt  = {pc_inc[31:28], inst[25:0], 2'b00};

   always_comb begin
      alu_r   = '0;
      reg_we  = 1'b0;
      mem_we  = 1'b0;
      wsel    = rd;
      next_pc = pc_inc;
      unique case (1'b1)
         is_add: begin
            alu_r  = rs_val + rt_val;
            reg_we = 1'b1;
         end
         is_sub: begin
            alu_r  = rs_val - rt_val;
            reg_we = 1'b1;
         end
         is_and: begin
            alu_r  = rs_val & rt_val;
            reg_we = 1'b1;
         end
         is_or: begin
            alu_r  = rs_val | rt_val;
            reg_we = 1'b1;
         end
         is_slt: begin
            alu_r  = {31'b0, $signed(rs_val) < $signed(rt_val)};
            reg_we = 1'b1;
         end
         is_addi, is_lw: begin
            alu_r  = rs_val + simm;
            reg_we = 1'b1;
            wsel   = rt;
         end
         is_sw: begin
            alu_r  = rs_val + simm;
            mem_we = 1'b1;
         end
         is_beq: begin
            alu_r = rs_val - rt_val;
            if (alu_r == 32'd0)
               next_pc = br_tgt;
         end
         is_j: next_pc = j_tgt;
         default: ;
      endcase
   end

   // Data RAM address and write-back mux sit outside the decoder to keep
   // the ALU->RAM->regfile path free of a combinational self-loop.
   assign maddr  = alu_r[AW+1:2];
   assign rd_mem = ram[maddr];
   assign wdata  = is_lw ? rd_mem : alu_r;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pc <= '0;
         for (int i = 0; i < 32; i++)
            regs[i] <= '0;
      end else begin
         pc <= next_pc;
         if (reg_we && (wsel != 5'd0))
            regs[wsel] <= wdata;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < MEM_WORDS; i++)
            ram[i] <= '0;
      end else if (mem_we) begin
         ram[maddr] <= rt_val;
      end
   end

   assign dbg.PC   = pc;
   assign dbg.INST = inst;
   assign dbg.R    = alu_r;
endmodule

// File: tb/tb_single_cycle_cpu.sv
// Scoreboard bench for single_cycle_cpu: expected PC/R trace is queued
// per phase and compared cycle by cycle against the debug bus.
module tb_single_cycle_cpu;
   localparam logic [31:0] PROG [64] = '{
      0:  32'h00A05020,
      1:  32'h8C0C0004,
      2:  32'h01806820,
      3:  32'h20010005,
      4:  32'h20020003,
      5:  32'h00221820,
      6:  32'h00222022,
      7:  32'h00222024,
      8:  32'h00222025,
      9:  32'h0041302A,
      10: 32'hAC030004,
      11: 32'h8C050004,
      12: 32'h00A03820,
      13: 32'h10210001,
      14: 32'h20090063,
      15: 32'h10220001,
      16: 32'hFC01FFFF,
      17: 32'h00221827,
      18: 32'h00604020,
      19: 32'h10000002,
      20: 32'h20090063,
      21: 32'h08000000,
      22: 32'h1000FFFE,
      default: 32'h0
   };

   typedef struct {
      logic [31:0] pc;
      logic [31:0] r;
   } exp_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   step;
   exp_t q [$];

   single_cycle_cpu_if bus ();

   single_cycle_cpu #(
      .MEM_WORDS (64),
      .IMEM_INIT (PROG)
   ) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .dbg   (bus)
   );

   initial clk = 1'b0;
   always #25 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic [31:0] r);
      exp_t e;
      e.pc = pc;
      e.r  = r;
      q.push_back(e);
   endtask

   // Called just after a falling edge; pops one entry per cycle.
   task automatic drain();
      exp_t e;
      logic [31:0] w;
      while (q.size() > 0) begin
         #1;
         e = q.pop_front();
         w = PROG[e.pc[7:2]];
         chk($sformatf("pc#%0d", step), bus.PC, e.pc);
         chk($sformatf("inst#%0d", step), bus.INST, w);
         chk($sformatf("r#%0d", step), bus.R, e.r);
         step++;
         @(negedge clk);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      step  = 0;
      rst_n = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", bus.PC, 32'h0);
      chk("rst_inst", bus.INST, 32'h00A05020);
      chk("rst_r", bus.R, 32'h0);

      @(negedge clk);
      rst_n = 1'b1;

      // first pass: registers and RAM all zero
      push(32'h00, 32'd0);
      push(32'h04, 32'd4);
      push(32'h08, 32'd0);
      push(32'h0C, 32'd5);
      push(32'h10, 32'd3);
      push(32'h14, 32'd8);
      push(32'h18, 32'd2);
      push(32'h1C, 32'd1);
      push(32'h20, 32'd7);
      push(32'h24, 32'd1);
      push(32'h28, 32'd4);
      push(32'h2C, 32'd4);
      push(32'h30, 32'd8);
      push(32'h34, 32'd0);
      push(32'h3C, 32'd2);
      push(32'h40, 32'd0);
      push(32'h44, 32'd0);
      push(32'h48, 32'd8);
      push(32'h4C, 32'd0);
      push(32'h58, 32'd0);
      push(32'h54, 32'd0);
      // loop after j 0: $5 = 8, RAM word 1 = 8
      push(32'h00, 32'd8);
      push(32'h04, 32'd4);
      push(32'h08, 32'd8);
      push(32'h0C, 32'd5);
      push(32'h10, 32'd3);
      drain();

      // PC 0x14 (add $3) is pending; reset mid-cycle
      #5;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_pc", bus.PC, 32'h0);
      chk("mid_rst_r", bus.R, 32'h0);
      @(posedge clk);
      #1;
      chk("hold_rst_pc", bus.PC, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // registers and RAM cleared again
      push(32'h00, 32'd0);
      push(32'h04, 32'd4);
      push(32'h08, 32'd0);
      push(32'h0C, 32'd5);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
